// File: rtl/apu_pwm_mixer.sv
// apu_pwm_mixer: sums unmuted channel samples once per frame and drives the
// resulting level onto a 1-bit audio pin, either as fixed-period PWM or as a
// first-order sigma-delta bitstream. All state advances only on ce ticks.
module apu_pwm_mixer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic [CHANNELS-1:0]       mute,
  input  logic                      mode,
  output logic                      pwm,
  output logic                      frame,
  output logic                      active
);

  // Full-scale level, which is also the frame length in ce ticks.
  localparam int MAXSUM = CHANNELS * ((1 << WIDTH) - 1);
  // Smallest width that can hold MAXSUM itself (level may equal full scale).
  localparam int SW = $clog2(MAXSUM + 1);

  localparam logic [SW-1:0] LAST_CNT = SW'(MAXSUM - 1);
  localparam logic [SW:0]   FULL     = (SW + 1)'(MAXSUM);

  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] level_q, level_d;
  logic [SW-1:0] acc_q, acc_d;
  logic          mode_q, mode_d;
  logic          pwm_q, pwm_d;
  logic          frame_q, frame_d;
  logic          active_q, active_d;

  logic [SW-1:0] mixSum;
  logic [SW:0]   sdSum;
  logic          boundary;

  assign pwm    = pwm_q;
  assign frame  = frame_q;
  assign active = active_q;

  // Mix the unmuted channels; the result can never exceed MAXSUM so no clamp.
  always_comb begin
    mixSum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!mute[k]) begin
        mixSum = mixSum + SW'(sample[k*WIDTH +: WIDTH]);
      end
    end
  end

  // Next-state: counter/modulator advance on ce, frame boundary latches new inputs.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    pwm_d    = pwm_q;
    active_d = active_q;
    boundary = ce && (cnt_q == LAST_CNT);
    frame_d  = boundary;
    sdSum    = {1'b0, acc_q} + {1'b0, level_q};

    if (ce) begin
      cnt_d = boundary ? '0 : cnt_q + SW'(1);

      if (!mode_q) begin
        pwm_d = (cnt_q < level_q);
      end else if (sdSum >= FULL) begin
        pwm_d = 1'b1;
        acc_d = SW'(sdSum - FULL);
      end else begin
        pwm_d = 1'b0;
        acc_d = sdSum[SW-1:0];
      end

      if (boundary) begin
        level_d  = mixSum;
        mode_d   = mode;
        active_d = (mixSum != '0);
        // A fresh sigma-delta run must start from a clean accumulator.
        if (mode != mode_q) begin
          acc_d = '0;
        end
      end
    end
  end

  // State register with synchronous reset taking priority over ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      level_q  <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      pwm_q    <= 1'b0;
      frame_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
      frame_q  <= frame_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_apu_pwm_mixer.sv
// tb_apu_pwm_mixer: self-checking bench for apu_pwm_mixer at default
// parameters. A behavioural model tracks frame position, latched level and
// the cumulative sigma-delta level total; the 1-bit stream is derived from
// floor(total/MAXSUM) increments rather than from an accumulator.
module tb_apu_pwm_mixer;

  localparam int M = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] sample = '0;
  logic [3:0]  mute = '0;
  logic        mode = 1'b0;
  logic        pwm;
  logic        frame;
  logic        active;

  int checks = 0;
  int failures = 0;
  int clkCount = 0;

  // Reference model state
  int     mPos;
  int     mLevel;
  logic   mMode;
  longint mTotal;
  logic   expPwm;
  logic   expFrame;
  logic   expActive;

  apu_pwm_mixer dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .sample (sample),
    .mute   (mute),
    .mode   (mode),
    .pwm    (pwm),
    .frame  (frame),
    .active (active)
  );

  always #5 clk = ~clk;

  function automatic int mixLevel();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      if (!mute[k]) s += int'((sample >> (4 * k)) & 16'h000F);
    end
    return s;
  endfunction

  // Advance the model by one clk with the current inputs, then clock the DUT.
  task automatic tick(input logic ceVal);
    longint prev;
    int     nl;
    ce = ceVal;
    if (rst) begin
      mPos = 0; mLevel = 0; mMode = 1'b0; mTotal = 0;
      expPwm = 1'b0; expFrame = 1'b0; expActive = 1'b0;
    end else begin
      expFrame = 1'b0;
      if (ceVal) begin
        if (!mMode) begin
          expPwm = (mPos < mLevel);
        end else begin
          prev = mTotal;
          mTotal = mTotal + mLevel;
          expPwm = ((mTotal / M) != (prev / M));
        end
        if (mPos == M - 1) begin
          mPos = 0;
          nl = mixLevel();
          if (mode !== mMode) mTotal = 0;
          mMode = mode;
          mLevel = nl;
          expActive = (nl != 0);
          expFrame = 1'b1;
        end else begin
          mPos++;
        end
      end
    end
    @(posedge clk);
    #1;
    clkCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1);
    checks++;
    if ({pwm, frame, active} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset clk=%0d pwm/frame/active got=%b exp=000", clkCount, {pwm, frame, active});
    end
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    sample = 16'hFFFF; mute = 4'h0; mode = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      tick(1'b1);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL first_frame_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
      checks++;
      if ({pwm, frame, active} !== {(i > 60), (i == 60 || i == 120), (i >= 60)}) begin
        failures++;
        $display("[TB] FAIL first_frame_tick%0d got=%b exp=%b", i, {pwm, frame, active}, {(i > 60), (i == 60 || i == 120), (i >= 60)});
      end
    end
  endtask

  task automatic test_pwm_pattern();
    int ones;
    sample = 16'h4321; mute = 4'h0; mode = 1'b0;
    for (int f = 0; f < 2; f++) begin
      ones = 0;
      for (int i = 0; i < M; i++) begin
        tick(1'b1);
        if (pwm === 1'b1) ones++;
        checks++;
        if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
          failures++;
          $display("[TB] FAIL pwm_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
        end
        if (f == 1) begin
          checks++;
          if (pwm !== (i < 10)) begin
            failures++;
            $display("[TB] FAIL pwm_level10 i=%0d got=%b exp=%b", i, pwm, (i < 10));
          end
        end
      end
      if (f == 1) begin
        checks++;
        if (ones != 10) begin
          failures++;
          $display("[TB] FAIL pwm_duty got=%0d exp=10", ones);
        end
      end
    end
  endtask

  task automatic test_sigma_delta();
    mode = 1'b1; sample = 16'h5555;
    for (int i = 0; i < M; i++) begin
      tick(1'b1);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL sd_entry_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
    end
    for (int i = 0; i < 2 * M; i++) begin
      if (i == 30) sample = 16'h00FF;
      tick(1'b1);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL sd_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
      checks++;
      if (pwm !== ((i < M) ? ((i % 3) == 2) : ((i % 2) == 1))) begin
        failures++;
        $display("[TB] FAIL sd_pattern i=%0d got=%b exp=%b", i, pwm, ((i < M) ? ((i % 3) == 2) : ((i % 2) == 1)));
      end
    end
  endtask

  task automatic test_mute();
    mode = 1'b0; sample = 16'hFFFF; mute = 4'b0101;
    for (int i = 0; i < 3 * M; i++) begin
      if (i == M + 20) mute = 4'b1111;
      tick(1'b1);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL mute_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
      if (i >= M) begin
        checks++;
        if ({pwm, active} !== {(i < M + 30), (i < 2 * M - 1)}) begin
          failures++;
          $display("[TB] FAIL mute_level i=%0d pwm/active got=%b exp=%b", i, {pwm, active}, {(i < M + 30), (i < 2 * M - 1)});
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int ones;
    sample = 16'h4321; mute = 4'h0; mode = 1'b0;
    ones = 0;
    for (int i = 0; i < 3 * M; i++) begin
      if (i == M + 25) mode = 1'b1;
      tick(1'b1);
      if (i >= 2 * M && pwm === 1'b1) ones++;
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL mode_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
      if (i >= M) begin
        checks++;
        if (pwm !== ((i < 2 * M) ? (i - M < 10) : (((i - 2 * M) % 6) == 5))) begin
          failures++;
          $display("[TB] FAIL mode_pattern i=%0d got=%b exp=%b", i, pwm, ((i < 2 * M) ? (i - M < 10) : (((i - 2 * M) % 6) == 5)));
        end
      end
    end
    checks++;
    if (ones != 10) begin
      failures++;
      $display("[TB] FAIL mode_sd_duty got=%0d exp=10", ones);
    end
  endtask

  task automatic test_sparse_ce_reset();
    int ceTicks;
    int frameAt;
    mode = 1'b0; sample = 16'h2222; mute = 4'h0;
    for (int t = 0; t < 40 * 6; t++) begin
      tick((t % 6) == 0);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL sparse_model clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
    end
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    checks++;
    if ({pwm, frame, active} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL sparse_reset got=%b exp=000", {pwm, frame, active});
    end
    ceTicks = 0;
    frameAt = -1;
    for (int t = 0; t < 70 * 6 && frameAt < 0; t++) begin
      tick((t % 6) == 0);
      if ((t % 6) == 0) ceTicks++;
      if (frame === 1'b1) frameAt = ceTicks;
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL sparse_after_reset clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
    end
    checks++;
    if (frameAt != M) begin
      failures++;
      $display("[TB] FAIL sparse_frame_distance got=%0d exp=%0d", frameAt, M);
    end
    tick(1'b0);
    checks++;
    if (frame !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sparse_frame_width got=%b exp=0", frame);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 99) < 3) begin
        sample = 16'($urandom);
        mute = 4'($urandom);
        mode = 1'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick($urandom_range(0, 2) != 0);
      checks++;
      if ({pwm, frame, active} !== {expPwm, expFrame, expActive}) begin
        failures++;
        $display("[TB] FAIL random clk=%0d got=%b exp=%b", clkCount, {pwm, frame, active}, {expPwm, expFrame, expActive});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pwm_pattern();
    test_sigma_delta();
    test_mute();
    test_mode_switch();
    test_sparse_ce_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
